// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_fifo
// Description : First-word fall-through FIFO that captures {carry, result}
//               pairs from the ALU. It reports the fill level and a sticky
//               drop flag. Optional macro ALU_FIFO_CARRY_STATS_EN adds a
//               saturating counter of accepted entries with carry set.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_result,
    input  logic                       in_carry,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_result,
    output logic                       out_carry,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clr_ovf,
    output logic [15:0]                carry_cnt
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [WIDTH:0]       r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_overflow;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_drop;
    logic [WIDTH:0]       w_head;

    // Handshake qualifiers; reset masks both sides so nothing moves in a reset cycle.
    assign in_ready  = !rst && (r_count != c_FULL);
    assign out_valid = !rst && (r_count != '0);
    assign w_wr      = in_valid && in_ready;
    assign w_rd      = out_valid && out_ready;
    assign w_drop    = in_valid && !in_ready && !rst;

    assign w_head     = r_mem[r_rd_ptr];
    assign out_result = w_head[WIDTH-1:0];
    assign out_carry  = w_head[WIDTH];
    assign count      = r_count;
    assign overflow   = r_overflow;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {in_carry, in_result};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_rd && !w_wr) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef ALU_FIFO_CARRY_STATS_EN
    logic [15:0] r_carry_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry_cnt <= '0;
        end else if (w_wr && in_carry && (r_carry_cnt != 16'hFFFF)) begin
            r_carry_cnt <= r_carry_cnt + 16'd1;
        end
    end

    assign carry_cnt = r_carry_cnt;
`else
    assign carry_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire
